// File: rtl/darkbus_initiator.sv
// device_bus initiator: one core request at a time, IDLE -> ACCESS -> TURN.
// Define DARKBUS_TIMEOUT_EN to abort accesses whose ack never arrives.
module darkbus_initiator #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        XCLK,
  input  logic        XRES,
  input  logic        CORE_REQ,
  input  logic        CORE_WE,
  input  logic [31:0] CORE_ADDR,
  input  logic [31:0] CORE_WDATA,
  output logic        CORE_RDY,
  output logic        CORE_DONE,
  output logic [31:0] CORE_RDATA,
  output logic        CORE_ERR,
  output logic [31:0] BUS_ADDR,
  output logic        BUS_EN,
  output logic        BUS_RE,
  output logic        BUS_WE,
  output logic [31:0] BUS_DOUT,
  output logic        BUS_DOE,
  input  logic [31:0] BUS_DIN,
  input  logic        BUS_RACK,
  input  logic        BUS_WACK
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] TURN   = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        done_q, done_d;
  logic        rdy_q, rdy_d;
  logic        accept;
  logic        ack;
  logic        in_access;

`ifdef DARKBUS_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  assign cnt_inc = cnt_q + 1'b1;
`else
  logic unused_cfg;
  assign unused_cfg = ^{CNT_W'(TIMEOUT)};
`endif

  assign accept    = CORE_REQ & rdy_q;
  // only the ack that matches the access direction counts
  assign ack       = we_q ? BUS_WACK : BUS_RACK;
  assign in_access = (state_q == ACCESS);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    done_d  = 1'b0;
`ifdef DARKBUS_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (|CORE_ADDR[1:0]) begin
            done_d  = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            addr_d  = CORE_ADDR;
            we_d    = CORE_WE;
            wdata_d = CORE_WDATA;
            state_d = ACCESS;
`ifdef DARKBUS_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      ACCESS: begin
        if (ack) begin
          rdata_d = we_q ? 32'h0 : BUS_DIN;
          err_d   = 1'b0;
          done_d  = 1'b1;
          state_d = TURN;
        end
`ifdef DARKBUS_TIMEOUT_EN
        else if (cnt_inc == CNT_W'(TIMEOUT)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = TURN;
        end else begin
          cnt_d = cnt_inc;
        end
`endif
      end
      TURN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge XCLK or negedge XRES) begin
    if (!XRES) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      done_q  <= done_d;
      rdy_q   <= rdy_d;
    end
  end

`ifdef DARKBUS_TIMEOUT_EN
  always_ff @(posedge XCLK or negedge XRES) begin
    if (!XRES) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign CORE_RDY   = rdy_q;
  assign CORE_DONE  = done_q;
  assign CORE_RDATA = rdata_q;
  assign CORE_ERR   = err_q;

  assign BUS_ADDR = addr_q;
  assign BUS_EN   = in_access;
  assign BUS_RE   = in_access & ~we_q;
  assign BUS_WE   = in_access & we_q;
  assign BUS_DOE  = in_access & we_q;
  assign BUS_DOUT = BUS_DOE ? wdata_q : 32'h0;

endmodule

// File: doc/darkbus_initiator.md
Name: darkbus_initiator

Overview:
- Initiator (producer) end of the device_bus protocol.
- Accepts single read/write requests from a core-side valid/ready port, drives the bus address and strobes, and waits for the device's registered RACK/WACK.
- Returns read data or a write completion to the core.
- Sits between the core's load/store/fetch path and any device_bus consumer: ROM, RAM or I/O.

Parameters:
- TIMEOUT, 255: cycles to wait for RACK/WACK before aborting. Used only with DARKBUS_TIMEOUT_EN.
- CNT_W, 8: timeout counter width; must satisfy 2**CNT_W > TIMEOUT.

Ports:
- XCLK  in  1  clock; all state changes on posedge.
- XRES  in  1  asynchronous, active-low reset.
- CORE_REQ  in  1  request valid.
- CORE_WE  in  1  1 = write, 0 = read.
- CORE_ADDR  in  32  byte address.
- CORE_WDATA  in  32  write data.
- CORE_RDY  out  1  request accepted this cycle (REQ & RDY = handshake).
- CORE_DONE  out  1  one-cycle completion pulse.
- CORE_RDATA  out  32  read data; valid while CORE_DONE=1.
- CORE_ERR  out  1  error flag; valid while CORE_DONE=1.
- BUS  device_bus.prod  -  drives ADDR, EN, RE, WE; drives DATA only for writes; samples DATA, RACK, WACK.

Behaviour:
- Reset (XRES=0, async): state IDLE.
  - CORE_RDY=0, CORE_DONE=0, CORE_RDATA=0, CORE_ERR=0.
  - BUS.EN=0, RE=0, WE=0, ADDR=0; BUS.DATA released (Z).
  - Timeout counter cleared.
- States: IDLE, ACCESS, TURN.
- IDLE:
  - CORE_RDY=1.
  - On REQ & RDY with CORE_ADDR[1:0]!=0: no bus access. Next cycle CORE_DONE=1, CORE_ERR=1, CORE_RDATA=0. Stay IDLE.
  - On REQ & RDY, aligned: latch ADDR, WE and WDATA; go to ACCESS.
- ACCESS:
  - BUS.EN=1, BUS.ADDR=latched address, RE=~we, WE=we.
  - For writes, BUS.DATA=latched WDATA; otherwise Z.
  - CORE_RDY=0.
  - Wait for the matching ack: RACK for reads, WACK for writes.
  - On the ack cycle, capture BUS.DATA into CORE_RDATA for reads (writes give CORE_RDATA=0). Go to TURN.
- TURN:
  - EN, RE and WE low; DATA released; CORE_DONE=1 with CORE_ERR=0; CORE_RDY=0. Next state IDLE.
  - Acks seen in TURN are stale because the device registers them from EN and must be ignored.
- Latency against a device that acks on the first edge after EN:
  - accept at edge 0 → EN high cycle 1 → ack seen cycle 2 → CORE_DONE cycle 3 → RDY again cycle 4.
  - Throughput: 1 access per 4 cycles.
- CORE_DONE is exactly one cycle; CORE_RDATA and CORE_ERR hold until the next CORE_DONE.
- A non-matching ack (WACK during a read, RACK during a write) is ignored.
- Bus outputs are registered; no combinational path from CORE_* to BUS.
- Reset asserted mid-ACCESS: bus strobes drop immediately (async). No CORE_DONE for the aborted access.

Optional Feature:
- Macro: DARKBUS_TIMEOUT_EN.
- Defined:
  - The counter clears on entry to ACCESS and increments each ACCESS cycle without the matching ack.
  - When the count reaches TIMEOUT, go to TURN with CORE_ERR=1 and CORE_RDATA=0.
  - An ack arriving in the same cycle as the count reaching TIMEOUT wins: normal completion, ERR=0.
- Not defined:
  - No counter logic; ACCESS waits indefinitely.
  - CORE_ERR is set only by misalignment.

Test Plan:
- Read: model ROM word 0 = 0x00000013, word 5 = 0xDEADBEEF. Issue read of 0x14 at edge 0 → BUS.EN=1, RE=1, ADDR=0x14 in cycle 1. In cycle 3: CORE_DONE=1, CORE_RDATA=0xDEADBEEF, CORE_ERR=0.
- Write: write 0xA5A5_0001 to 0x100 with a RAM model acking WACK → BUS.DATA=0xA5A50001 while EN=1, RE=0, WE=1. CORE_DONE arrives in cycle 3. Read-back of 0x100 returns 0xA5A50001.
- Misaligned: read of 0x102 → no BUS.EN pulse; next cycle CORE_DONE=1, CORE_ERR=1, CORE_RDATA=0.
- Slow device and back-to-back: the device delays RACK by 3 cycles. Two reads are held on REQ → EN stays high until the ack, each read completes with the correct data, stale RACK in TURN is ignored, and exactly 2 DONE pulses are seen.
- Timeout (DARKBUS_TIMEOUT_EN, TIMEOUT=4): the device never acks → CORE_DONE=1, CORE_ERR=1 after 4 ACCESS cycles, then RDY=1. Without the macro, EN stays high for 100+ cycles and no DONE is produced.
- Reset mid-ACCESS: drop XRES in cycle 2 of an access → EN, RE, WE=0 and DATA=Z immediately. After release, RDY=1 and no spurious DONE.
